// File: rtl/systolic_feeder_3x3.sv
// Operand feeder for the 3x3 systolic matrix-multiply array.
// Latency: first skewed beat EN_LEAD+1 cycles after the final load element; DONE EN_LEAD+8 cycles after it.
// Backpressure: LOAD_READY is high only while collecting operands; LOAD_VALID is ignored otherwise.
module systolic_feeder_3x3 #(
  parameter int WIDTH   = 4,
  parameter int EN_LEAD = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  output logic [WIDTH-1:0] A_ROW0,
  output logic [WIDTH-1:0] A_ROW1,
  output logic [WIDTH-1:0] A_ROW2,
  output logic [WIDTH-1:0] B_COL0,
  output logic [WIDTH-1:0] B_COL1,
  output logic [WIDTH-1:0] B_COL2,
  output logic             ENABLE,
  output logic             DONE
);

  typedef enum logic [1:0] {S_LOAD, S_LEAD, S_FEED, S_DONE} state_t;

  // Last value of the lead counter before moving on to FEED.
  localparam logic [7:0] LEAD_LAST = 8'((EN_LEAD > 0) ? EN_LEAD - 1 : 0);

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [7:0]       r_lead_cnt;
  logic [2:0]       r_beat;
  logic             r_ready;
  logic             r_enable;
  logic             r_done;
  logic [WIDTH-1:0] r_buf [0:17];   // 0..8 hold A row-major, 9..17 hold B row-major
  logic [WIDTH-1:0] r_a   [0:2];
  logic [WIDTH-1:0] r_b   [0:2];

  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_a [0:2];
  logic [WIDTH-1:0] w_b [0:2];

  // Only the LOAD state consumes stream elements.
  assign w_xfer = (r_state == S_LOAD) && r_ready && LOAD_VALID;
  assign w_last = (r_cnt == 5'd17);

  // Skewed beat selection: row/column i sees element k at beat t = i + k.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_a[i] = '0;
      w_b[i] = '0;
      for (int k = 0; k < 3; k++) begin
        if (int'(r_beat) == i + k) begin
          w_a[i] = r_buf[i*3 + k];
          w_b[i] = r_buf[9 + k*3 + i];
        end
      end
    end
  end

  // Operand buffer; contents are irrelevant until a full load completes, so no reset.
  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      r_buf[r_cnt] <= LOAD_DATA;
    end
  end

  // Control FSM; outputs are registered and trail the state by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_LOAD;
      r_cnt      <= '0;
      r_lead_cnt <= '0;
      r_beat     <= '0;
      r_ready    <= 1'b1;
      r_enable   <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      case (r_state)
        S_LOAD: begin
          // READY drops on the edge that takes the final element and
          // comes back one cycle after the DONE pulse.
          r_ready <= 1'b1;
          if (w_xfer) begin
            if (w_last) begin
              r_ready <= 1'b0;
              r_state <= (EN_LEAD > 0) ? S_LEAD : S_FEED;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_LEAD: begin
          r_enable <= 1'b1;
          if (r_lead_cnt == LEAD_LAST) begin
            r_lead_cnt <= '0;
            r_state    <= S_FEED;
          end else begin
            r_lead_cnt <= r_lead_cnt + 8'd1;
          end
        end
        S_FEED: begin
          r_enable <= 1'b1;
          for (int i = 0; i < 3; i++) begin
            r_a[i] <= w_a[i];
            r_b[i] <= w_b[i];
          end
          // Beats 5 and 6 select nothing and act as the flush beats.
          if (r_beat == 3'd6) begin
            r_beat  <= '0;
            r_state <= S_DONE;
          end else begin
            r_beat <= r_beat + 3'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign LOAD_READY = r_ready;
  assign ENABLE     = r_enable;
  assign DONE       = r_done;
  assign A_ROW0     = r_a[0];
  assign A_ROW1     = r_a[1];
  assign A_ROW2     = r_a[2];
  assign B_COL0     = r_b[0];
  assign B_COL1     = r_b[1];
  assign B_COL2     = r_b[2];

endmodule

// File: tb/tb_systolic_feeder_3x3.sv
// Directed bench for systolic_feeder_3x3: two instances (EN_LEAD=1 and EN_LEAD=0) share one load stream.
// Each run captures 12 cycles of outputs after the final load element and compares them cycle by cycle.
module tb_systolic_feeder_3x3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD_VALID;
  logic [3:0] LOAD_DATA;

  logic       rdy1, en1, done1;
  logic [3:0] a0_1, a1_1, a2_1, b0_1, b1_1, b2_1;
  logic       rdy0, en0, done0;
  logic [3:0] a0_0, a1_0, a2_0, b0_0, b1_0, b2_0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  ma [9];
  logic [3:0]  mb [9];
  logic [31:0] cap1 [12];
  logic [31:0] cap0 [12];

  always #5 CLK = ~CLK;

  systolic_feeder_3x3 #(.WIDTH(4), .EN_LEAD(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .LOAD_READY(rdy1), .A_ROW0(a0_1), .A_ROW1(a1_1), .A_ROW2(a2_1),
    .B_COL0(b0_1), .B_COL1(b1_1), .B_COL2(b2_1), .ENABLE(en1), .DONE(done1)
  );

  systolic_feeder_3x3 #(.WIDTH(4), .EN_LEAD(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .LOAD_READY(rdy0), .A_ROW0(a0_0), .A_ROW1(a1_0), .A_ROW2(a2_0),
    .B_COL0(b0_0), .B_COL1(b1_0), .B_COL2(b2_0), .ENABLE(en0), .DONE(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ready, enable, done, a0, a1, a2, b0, b1, b2} packed into the low 27 bits.
  function automatic logic [31:0] pk(input logic r, input logic e, input logic d,
                                     input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] x2,
                                     input logic [3:0] y0, input logic [3:0] y1, input logic [3:0] y2);
    return {5'd0, r, e, d, x0, x1, x2, y0, y1, y2};
  endfunction

  // Expected packed outputs c cycles after the edge that took element 17.
  function automatic logic [31:0] model(input int lead, input int c);
    logic [3:0] a [3];
    logic [3:0] b [3];
    int t;
    t = c - lead - 1;
    for (int i = 0; i < 3; i++) begin
      a[i] = 4'd0;
      b[i] = 4'd0;
      if (t >= 0 && t <= 6 && t - i >= 0 && t - i <= 2) begin
        a[i] = ma[i*3 + (t - i)];
        b[i] = mb[(t - i)*3 + i];
      end
    end
    return pk(c >= lead + 9, c >= 1 && c <= lead + 7, c == lead + 8,
              a[0], a[1], a[2], b[0], b[1], b[2]);
  endfunction

  task automatic load(input bit gaps, input bit hold_f);
    bit ok;
    ok = 1'b1;
    for (int e = 0; e < 18; e++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          LOAD_VALID = 1'b0;
          LOAD_DATA  = 4'hF;
          @(posedge CLK); #1;
        end
      end
      LOAD_VALID = 1'b1;
      LOAD_DATA  = (e < 9) ? ma[e] : mb[e - 9];
      if (!(rdy1 && rdy0)) ok = 1'b0;
      @(posedge CLK); #1;
    end
    chk("ready_during_load", 32'(ok), 32'd1);
    if (hold_f) begin
      LOAD_DATA = 4'hF;
    end else begin
      LOAD_VALID = 1'b0;
    end
  endtask

  task automatic capture(input bit hold_f);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
      end
      cap1[c] = pk(rdy1, en1, done1, a0_1, a1_1, a2_1, b0_1, b1_1, b2_1);
      cap0[c] = pk(rdy0, en0, done0, a0_0, a1_0, a2_0, b0_0, b1_0, b2_0);
      if (hold_f && c == 8) LOAD_VALID = 1'b0;
    end
  endtask

  task automatic check_run(input string tag);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("%s_lead1_c%0d", tag, c), cap1[c], model(1, c));
      chk($sformatf("%s_lead0_c%0d", tag, c), cap0[c], model(0, c));
    end
  endtask

  task automatic set_ident;
    for (int k = 0; k < 9; k++) begin
      ma[k] = 4'(k + 1);
      mb[k] = (k % 4 == 0) ? 4'd1 : 4'd0;
    end
  endtask

  initial begin
    logic [27:0] s_a0, s_a1, s_a2, s_b0, s_b1, s_b2;
    int ecnt1, ecnt0;

    RST        = 1'b0;
    LOAD_VALID = 1'b0;
    LOAD_DATA  = 4'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_lead1", pk(rdy1, en1, done1, a0_1, a1_1, a2_1, b0_1, b1_1, b2_1), 32'h0400_0000);
    chk("reset_lead0", pk(rdy0, en0, done0, a0_0, a1_0, a2_0, b0_0, b1_0, b2_0), 32'h0400_0000);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Identity B, no gaps: model plus hand-written beat sequences.
    set_ident();
    load(1'b0, 1'b0);
    capture(1'b0);
    check_run("ident");
    s_a0 = '0; s_a1 = '0; s_a2 = '0; s_b0 = '0; s_b1 = '0; s_b2 = '0;
    for (int t = 0; t < 7; t++) begin
      s_a0 = {s_a0[23:0], cap1[t+2][23:20]};
      s_a1 = {s_a1[23:0], cap1[t+2][19:16]};
      s_a2 = {s_a2[23:0], cap1[t+2][15:12]};
      s_b0 = {s_b0[23:0], cap1[t+2][11:8]};
      s_b1 = {s_b1[23:0], cap1[t+2][7:4]};
      s_b2 = {s_b2[23:0], cap1[t+2][3:0]};
    end
    chk("ident_a_row0_seq", 32'(s_a0), 32'h0123_0000);
    chk("ident_a_row1_seq", 32'(s_a1), 32'h0045_6000);
    chk("ident_a_row2_seq", 32'(s_a2), 32'h0007_8900);
    chk("ident_b_col0_seq", 32'(s_b0), 32'h0100_0000);
    chk("ident_b_col1_seq", 32'(s_b1), 32'h0001_0000);
    chk("ident_b_col2_seq", 32'(s_b2), 32'h0000_0100);
    ecnt1 = 0;
    ecnt0 = 0;
    for (int c = 0; c < 12; c++) begin
      ecnt1 += int'(cap1[c][25]);
      ecnt0 += int'(cap0[c][25]);
    end
    chk("enable_cycles_lead1", 32'(ecnt1), 32'd8);
    chk("enable_cycles_lead0", 32'(ecnt0), 32'd7);
    chk("done_cycle_lead1", cap1[9] & 32'h0700_0000, 32'h0100_0000);
    chk("first_beat_lead0_a0", 32'(cap0[1][23:20]), 32'd1);

    // Same operands with random gaps in LOAD_VALID.
    load(1'b1, 1'b0);
    capture(1'b0);
    check_run("stall");

    // Dense all-3s.
    for (int k = 0; k < 9; k++) begin
      ma[k] = 4'd3;
      mb[k] = 4'd3;
    end
    load(1'b0, 1'b0);
    capture(1'b0);
    check_run("dense3");

    // Mixed operands loaded with VALID held high and data 0xF after the last element.
    for (int k = 0; k < 9; k++) begin
      ma[k] = 4'(9 - k);
      mb[k] = 4'(k + 6);
    end
    load(1'b1, 1'b1);
    capture(1'b1);
    check_run("ignored");

    // All-15s right after: proves the load count restarted at zero.
    for (int k = 0; k < 9; k++) begin
      ma[k] = 4'hF;
      mb[k] = 4'hF;
    end
    load(1'b0, 1'b0);
    capture(1'b0);
    check_run("dense15");

    // Reset while the EN_LEAD=1 instance shows FEED beat 3.
    set_ident();
    load(1'b0, 1'b0);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    chk("beat3_a_row1_before_reset", 32'(a1_1), 32'd6);
    RST = 1'b0;
    #1;
    chk("midfeed_reset_lead1", pk(rdy1, en1, done1, a0_1, a1_1, a2_1, b0_1, b1_1, b2_1), 32'h0400_0000);
    chk("midfeed_reset_lead0", pk(rdy0, en0, done0, a0_0, a1_0, a2_0, b0_0, b1_0, b2_0), 32'h0400_0000);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < 9; k++) begin
      ma[k] = 4'(k + 2);
      mb[k] = 4'(12 - k);
    end
    load(1'b0, 1'b0);
    capture(1'b0);
    check_run("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_3x3.md
Name: systolic_feeder_3x3

Overview:
Source side of the PE array's A_IN/B_IN/ENABLE interface for the 3x3 matrix-multiply array. It accepts two 3x3 operand matrices over a valid/ready load stream and buffers them. It then drives the array's left edge (A rows) and top edge (B columns) with the diagonal skew the systolic schedule needs, plus the shared ENABLE. It pulses DONE when the last product has reached PE(2,2).

Parameters:
WIDTH, 4, element width of A and B operands; must match the PE WIDTH.
EN_LEAD, 1, cycles ENABLE is raised before the first data beat, to cover the PE's one-cycle state-register latency (0 is legal).

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous active-low reset.
LOAD_VALID  input  1  LOAD_DATA holds a valid element.
LOAD_DATA  input  WIDTH  element stream: A[0][0..2], A[1][..], A[2][..], then B[0][..], B[1][..], B[2][..] (row-major).
LOAD_READY  output  1  feeder can accept an element.
A_ROW0, A_ROW1, A_ROW2  output  WIDTH each  A_IN of PE(i,0).
B_COL0, B_COL1, B_COL2  output  WIDTH each  B_IN of PE(0,j).
ENABLE  output  1  ENABLE to all nine PEs.
DONE  output  1  one-cycle pulse when feeding is complete.

Behaviour:
- Reset values: all outputs registered. A_ROWx = B_COLx = 0, ENABLE = 0, DONE = 0, LOAD_READY = 1, load count = 0, state = LOAD. Buffer contents don't care.
- A transfer occurs on a rising edge with LOAD_VALID && LOAD_READY. Load count goes 0..17. Elements 0-8 fill A and 9-17 fill B. Gaps in LOAD_VALID are allowed and stall the count.
- LOAD: LOAD_READY = 1, ENABLE = 0, data outputs = 0. On the 18th transfer, the next state is LEAD if EN_LEAD > 0, otherwise FEED. LOAD_READY drops on the same edge.
- LEAD: runs for EN_LEAD cycles. ENABLE = 1, LOAD_READY = 0, data outputs = 0.
- FEED: runs for 7 beats, t = 0..6, with ENABLE = 1.
  - A_ROWi = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - B_COLj = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - Beats 5 and 6 are all-zero flush beats. They let A[2][2]/B[2][2] propagate two hops to PE(2,2).
- DONE: one cycle. ENABLE = 0, data outputs = 0, DONE = 1, LOAD_READY = 0. Next state is LOAD with load count cleared.
- Latency: the first FEED beat appears EN_LEAD+1 cycles after the edge accepting element 17. DONE appears EN_LEAD+8 cycles after that edge.
- LOAD_VALID outside LOAD is ignored: no transfer, no buffer change.
- The feeder never clears PE sums. Back-to-back multiplies accumulate into SUM unless the array is reset between operations; this is the system integrator's responsibility.
- Asserting RST at any point, including mid-LEAD or mid-FEED, returns immediately to the reset values. Any partial load is discarded.
- Multiplication/accumulation width rules belong to the PE. The feeder only moves WIDTH-bit values unchanged.

Test Plan:
- Identity: A=[[1,2,3],[4,5,6],[7,8,9]], B=I, EN_LEAD=1, no gaps.
  - A_ROW0 over beats = 1,2,3,0,0,0,0. A_ROW1 = 0,4,5,6,0,0,0. A_ROW2 = 0,0,7,8,9,0,0.
  - B_COL1 = 0,0,1,0,0,0,0.
  - ENABLE high 8 cycles, then DONE for 1 cycle.
  - With a freshly reset 3x3 PE array attached, SUM(i,j) = A[i][j].
- Dense: A=B=all 3s, WIDTH=4, with array. Every SUM = 27 and MULTI_OVER = 0. All-15s: every SUM = 675 mod 256 = 163, with MULTI_OVER = 1 per PE semantics.
- Stalled load: insert a random LOAD_VALID gap before each of the 18 elements. The beat sequence is identical to the identity case, and LOAD_READY deasserts only after element 17.
- Ignored input: hold LOAD_VALID = 1 with data 0xF throughout LEAD/FEED. The outputs still match the loaded matrices, and after DONE the load count restarts at 0.
- Reset mid-feed: drop RST at FEED beat 3. All outputs return to 0 immediately and LOAD_READY = 1. A subsequent full load feeds correctly.
- EN_LEAD=0: the first beat is one cycle after element 17. ENABLE is high exactly 7 cycles.
